// File: rtl/ioctl_loader_pkg.sv
// Shared types and parameter helpers for the ioctl ROM loader.
// Window bases/sizes arrive as one packed vector; the helpers pull out one port's field.
package ioctl_loader_pkg;

  localparam int AW_DEFAULT = 25;
  localparam int MAX_PORTS  = 4;
  localparam int MAX_AW     = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK
  } fsm_state_e;

  function automatic logic [MAX_AW-1:0] window_field(
    input logic [MAX_PORTS*MAX_AW-1:0] vec,
    input int                          p,
    input int                          aw
  );
    logic [MAX_PORTS*MAX_AW-1:0] sh;
    logic [MAX_AW-1:0]           r;
    sh = vec >> (p * aw);
    r  = sh[MAX_AW-1:0];
    for (int i = 0; i < MAX_AW; i++) begin
      if (i >= aw) r[i] = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [MAX_AW-1:0] base_of(
    input logic [MAX_PORTS*MAX_AW-1:0] bases,
    input int                          p,
    input int                          aw
  );
    return window_field(bases, p, aw);
  endfunction

  function automatic logic [MAX_AW-1:0] size_of(
    input logic [MAX_PORTS*MAX_AW-1:0] sizes,
    input int                          p,
    input int                          aw
  );
    return window_field(sizes, p, aw);
  endfunction

endpackage

// File: rtl/ioctl_rom_loader_if.sv
// ioctl byte stream in, toggle-handshake SDRAM write ports out.
// slave = the loader; master = the data_io/sdram side driving it.
interface ioctl_rom_loader_if #(
  parameter int NUM_PORTS = 2,
  parameter int AW        = 25,
  parameter int PAW       = 23
);
  logic                      ioctl_download;
  logic [7:0]                ioctl_index;
  logic                      ioctl_wr;
  logic [AW-1:0]             ioctl_addr;
  logic [7:0]                ioctl_dout;
  logic [NUM_PORTS-1:0]      port_req;
  logic [NUM_PORTS-1:0]      port_ack;
  logic [NUM_PORTS*PAW-1:0]  port_a;
  logic [NUM_PORTS*2-1:0]    port_ds;
  logic [NUM_PORTS*16-1:0]   port_d;
  logic                      port_we;

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, port_ack,
    output port_req, port_a, port_ds, port_d, port_we
  );

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, port_ack,
    input  port_req, port_a, port_ds, port_d, port_we
  );
endinterface

// File: rtl/ioctl_port_window.sv
// One SDRAM port window: hit test on incoming address, rebase, registered port outputs.
// Outputs update one cycle after issue and then hold until the next issue.
module ioctl_port_window #(
  parameter int            AW   = 25,
  parameter int            PAW  = 23,
  parameter logic [AW-1:0] BASE = '0,
  parameter logic [AW-1:0] SIZE = '0
) (
  input  logic           clk_sys,
  input  logic           reset_n,
  input  logic [AW-1:0]  cmp_addr,
  input  logic [AW-1:0]  cur_addr,
  input  logic [7:0]     cur_data,
  input  logic           issue,
  output logic           hit,
  output logic           req,
  output logic [PAW-1:0] a,
  output logic [1:0]     ds,
  output logic [15:0]    d
);

  logic           borrow;
  logic [AW-1:0]  cmp_local, cur_local;
  logic           req_d, req_q;
  logic [PAW-1:0] a_d, a_q;
  logic [1:0]     ds_d, ds_q;
  logic [15:0]    d_d, d_q;

  always_comb begin
    // Borrow out of the rebase doubles as the addr < base test.
    {borrow, cmp_local} = {1'b0, cmp_addr} - {1'b0, BASE};
    hit       = ~borrow & (cmp_local < SIZE);
    cur_local = cur_addr - BASE;
    req_d = req_q;
    a_d   = a_q;
    ds_d  = ds_q;
    d_d   = d_q;
    if (issue) begin
      req_d = ~req_q;
      a_d   = PAW'(cur_local >> 1);
      ds_d  = {cur_local[0], ~cur_local[0]};
      d_d   = {cur_data, cur_data};
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      req_q <= 1'b0;
      a_q   <= '0;
      ds_q  <= '0;
      d_q   <= '0;
    end else begin
      req_q <= req_d;
      a_q   <= a_d;
      ds_q  <= ds_d;
      d_q   <= d_d;
    end
  end

  assign req = req_q;
  assign a   = a_q;
  assign ds  = ds_q;
  assign d   = d_q;

endmodule

// File: rtl/ioctl_rom_loader.sv
// Routes ioctl download bytes to every SDRAM port window they hit; owns rom_loaded and core reset.
// Request toggles two cycles after accept; one-byte skid absorbs a stalled ack, further bytes set overflow.
module ioctl_rom_loader
  import ioctl_loader_pkg::*;
#(
  parameter int                      NUM_PORTS  = 2,
  parameter int                      AW         = AW_DEFAULT,
  parameter int                      PAW        = 23,
  parameter logic [7:0]              DL_INDEX   = 8'd0,
  parameter logic [NUM_PORTS*AW-1:0] PORT_BASE  = {25'h0E000, 25'h0},
  parameter logic [NUM_PORTS*AW-1:0] PORT_SIZE  = {25'h1A100, 25'h28200},
  parameter int                      RESET_HOLD = 16
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                user_reset,
  ioctl_rom_loader_if.slave   bus,
  output logic                busy,
  output logic                overflow,
  output logic                rom_loaded,
  output logic                reset_out
);

  localparam logic [MAX_PORTS*MAX_AW-1:0] BASE_EXT = (MAX_PORTS*MAX_AW)'(PORT_BASE);
  localparam logic [MAX_PORTS*MAX_AW-1:0] SIZE_EXT = (MAX_PORTS*MAX_AW)'(PORT_SIZE);
  localparam int                          CW       = $clog2(RESET_HOLD + 1);
  localparam logic [CW-1:0]               HOLD     = CW'(RESET_HOLD);

  fsm_state_e           state_q, state_d;
  logic                 wr_q, dl_q;
  logic [AW-1:0]        cur_addr_q, cur_addr_d, skid_addr_q, skid_addr_d;
  logic [7:0]           cur_data_q, cur_data_d, skid_data_q, skid_data_d;
  logic [NUM_PORTS-1:0] cur_mask_q, cur_mask_d, skid_mask_q, skid_mask_d;
  logic                 skid_vld_q, skid_vld_d;
  logic                 overflow_q, overflow_d;
  logic                 pend_q, pend_d, loaded_q, loaded_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic                 accept, acc_hit, done, pop, busy_int, fall, hold_cond;
  logic [NUM_PORTS-1:0] hit, req, issue;
  logic                 hit_arr [NUM_PORTS];
  logic                 req_arr [NUM_PORTS];
  logic [PAW-1:0]       a_arr   [NUM_PORTS];
  logic [1:0]           ds_arr  [NUM_PORTS];
  logic [15:0]          d_arr   [NUM_PORTS];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    ioctl_port_window #(
      .AW  (AW),
      .PAW (PAW),
      .BASE(AW'(base_of(BASE_EXT, p, AW))),
      .SIZE(AW'(size_of(SIZE_EXT, p, AW)))
    ) u_win (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .cmp_addr(bus.ioctl_addr),
      .cur_addr(cur_addr_q),
      .cur_data(cur_data_q),
      .issue   (issue[p]),
      .hit     (hit_arr[p]),
      .req     (req_arr[p]),
      .a       (a_arr[p]),
      .ds      (ds_arr[p]),
      .d       (d_arr[p])
    );
  end

  always_comb begin
    hit         = '0;
    req         = '0;
    bus.port_a  = '0;
    bus.port_ds = '0;
    bus.port_d  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      hit[p]                    = hit_arr[p];
      req[p]                    = req_arr[p];
      bus.port_a[p*PAW +: PAW]  = a_arr[p];
      bus.port_ds[p*2 +: 2]     = ds_arr[p];
      bus.port_d[p*16 +: 16]    = d_arr[p];
    end
  end

  always_comb begin
    accept   = ~wr_q & bus.ioctl_wr & bus.ioctl_download & (bus.ioctl_index == DL_INDEX);
    acc_hit  = accept & (|hit);
    done     = &(~cur_mask_q | ~(bus.port_ack ^ req));
    busy_int = (state_q != IDLE) | skid_vld_q;
    pop      = skid_vld_q & ((state_q == IDLE) | ((state_q == WAIT_ACK) & done));

    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    cur_data_d  = cur_data_q;
    cur_mask_d  = cur_mask_q;
    skid_vld_d  = skid_vld_q;
    skid_addr_d = skid_addr_q;
    skid_data_d = skid_data_q;
    skid_mask_d = skid_mask_q;
    overflow_d  = overflow_q;
    issue       = '0;

    case (state_q)
      IDLE:     if (skid_vld_q || acc_hit) state_d = ISSUE;
      ISSUE: begin
        issue   = cur_mask_q;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: if (done) state_d = skid_vld_q ? ISSUE : IDLE;
      default:  state_d = IDLE;
    endcase

    if (pop) begin
      cur_addr_d = skid_addr_q;
      cur_data_d = skid_data_q;
      cur_mask_d = skid_mask_q;
      skid_vld_d = 1'b0;
    end else if (acc_hit && state_q == IDLE) begin
      cur_addr_d = bus.ioctl_addr;
      cur_data_d = bus.ioctl_dout;
      cur_mask_d = hit;
    end

    // A popping skid frees its slot in the same cycle, so a simultaneous byte refills it.
    if (acc_hit && (state_q != IDLE || skid_vld_q)) begin
      if (!skid_vld_q || pop) begin
        skid_vld_d  = 1'b1;
        skid_addr_d = bus.ioctl_addr;
        skid_data_d = bus.ioctl_dout;
        skid_mask_d = hit;
      end else begin
        overflow_d = 1'b1;
      end
    end

    fall      = dl_q & ~bus.ioctl_download & (bus.ioctl_index == DL_INDEX);
    pend_d    = (pend_q | fall) & busy_int;
    loaded_d  = loaded_q | ((pend_q | fall) & ~busy_int);
    hold_cond = user_reset | ~loaded_q;
    if (hold_cond)         cnt_d = HOLD;
    else if (cnt_q != '0)  cnt_d = cnt_q - CW'(1);
    else                   cnt_d = cnt_q;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      dl_q        <= 1'b0;
      cur_addr_q  <= '0;
      cur_data_q  <= '0;
      cur_mask_q  <= '0;
      skid_vld_q  <= 1'b0;
      skid_addr_q <= '0;
      skid_data_q <= '0;
      skid_mask_q <= '0;
      overflow_q  <= 1'b0;
      pend_q      <= 1'b0;
      loaded_q    <= 1'b0;
      cnt_q       <= HOLD;
    end else begin
      state_q     <= state_d;
      wr_q        <= bus.ioctl_wr;
      dl_q        <= bus.ioctl_download;
      cur_addr_q  <= cur_addr_d;
      cur_data_q  <= cur_data_d;
      cur_mask_q  <= cur_mask_d;
      skid_vld_q  <= skid_vld_d;
      skid_addr_q <= skid_addr_d;
      skid_data_q <= skid_data_d;
      skid_mask_q <= skid_mask_d;
      overflow_q  <= overflow_d;
      pend_q      <= pend_d;
      loaded_q    <= loaded_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.port_req = req;
  assign bus.port_we  = bus.ioctl_download | busy_int;
  assign busy         = busy_int;
  assign overflow     = overflow_q;
  assign rom_loaded   = loaded_q;
  assign reset_out    = hold_cond | (cnt_q != '0);

endmodule

// File: tb/tb_ioctl_rom_loader.sv
// Directed bench for ioctl_rom_loader: scoreboarded SDRAM writes, skid/overflow, rom_loaded and reset timing.
module tb_ioctl_rom_loader;

  localparam int NP  = 2;
  localparam int AW  = 25;
  localparam int PAW = 23;

  typedef struct {
    int          port;
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } wr_t;

  logic clk_sys    = 1'b0;
  logic reset_n    = 1'b0;
  logic user_reset = 1'b0;
  logic busy, overflow, rom_loaded, reset_out;

  int   n_chk     = 0;
  int   n_fail    = 0;
  int   write_cnt = 0;
  int   ack_delay = 2;
  logic [1:0] ack_hold = 2'b00;
  logic [1:0] last_req = 2'b00;
  int   pend_cnt [NP];
  wr_t  exp_q [$];

  always #5 clk_sys = ~clk_sys;

  ioctl_rom_loader_if #(.NUM_PORTS(NP), .AW(AW), .PAW(PAW)) bus ();

  ioctl_rom_loader #(
    .NUM_PORTS (NP),
    .AW        (AW),
    .PAW       (PAW),
    .DL_INDEX  (8'd0),
    .PORT_BASE ({25'h0E000, 25'h0}),
    .PORT_SIZE ({25'h1A100, 25'h28200}),
    .RESET_HOLD(16)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .user_reset(user_reset),
    .bus       (bus),
    .busy      (busy),
    .overflow  (overflow),
    .rom_loaded(rom_loaded),
    .reset_out (reset_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [24:0] tb_base(input int p);
    return (p == 0) ? 25'h0 : 25'h0E000;
  endfunction

  function automatic logic [24:0] tb_size(input int p);
    return (p == 0) ? 25'h28200 : 25'h1A100;
  endfunction

  task automatic push_byte(input logic [24:0] addr, input logic [7:0] data);
    logic [24:0] loc;
    for (int p = 0; p < NP; p++) begin
      loc = addr - tb_base(p);
      if (addr >= tb_base(p) && loc < tb_size(p))
        exp_q.push_back('{port: p, a: loc[23:1], ds: {loc[0], ~loc[0]}, d: {data, data}});
    end
  endtask

  task automatic send(input logic [24:0] addr, input logic [7:0] data, input bit expect_w);
    if (expect_w) push_byte(addr, data);
    bus.ioctl_addr = addr;
    bus.ioctl_dout = data;
    bus.ioctl_wr   = 1'b1;
    tick();
    bus.ioctl_wr   = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk_sys);
    while (busy && n < 200) begin
      n++;
      @(negedge clk_sys);
    end
    chk(tag, busy, 0);
  endtask

  // SDRAM side: detect request toggles, score them, and answer after ack_delay unless held.
  initial begin
    forever begin
      @(negedge clk_sys);
      if (!reset_n) begin
        bus.port_ack = '0;
        last_req     = '0;
        for (int p = 0; p < NP; p++) pend_cnt[p] = 0;
      end else begin
        for (int p = 0; p < NP; p++) begin
          if (bus.port_req[p] !== last_req[p]) begin
            wr_t e;
            last_req[p] = bus.port_req[p];
            write_cnt++;
            chk("write_expected", 64'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              chk("write_port", p, e.port);
              chk("write_a", bus.port_a[p*PAW +: PAW], e.a);
              chk("write_ds", bus.port_ds[p*2 +: 2], e.ds);
              chk("write_d", bus.port_d[p*16 +: 16], e.d);
            end
            pend_cnt[p] = ack_delay;
          end
          if (pend_cnt[p] > 0 && !ack_hold[p]) begin
            pend_cnt[p]--;
            if (pend_cnt[p] == 0) bus.port_ack[p] = bus.port_req[p];
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int cnt;
    logic busy_seen;

    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    repeat (3) tick();
    @(negedge clk_sys);
    chk("rst_req", bus.port_req, 0);
    chk("rst_a", bus.port_a, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_loaded", rom_loaded, 0);
    chk("rst_reset_out", reset_out, 1);

    tick();
    reset_n = 1'b1;
    bus.ioctl_download = 1'b1;
    tick();
    @(negedge clk_sys);
    chk("we_during_download", bus.port_we, 1);

    // Single byte into port 0 only; request toggles two cycles after accept.
    tick();
    push_byte(25'h00010, 8'hA5);
    bus.ioctl_addr = 25'h00010;
    bus.ioctl_dout = 8'hA5;
    bus.ioctl_wr   = 1'b1;
    tick();
    bus.ioctl_wr   = 1'b0;
    @(negedge clk_sys);
    chk("t1_req_n1", bus.port_req[0], 0);
    @(negedge clk_sys);
    chk("t1_req_n2", bus.port_req[0], 1);
    chk("t1_a0", bus.port_a[22:0], 23'd8);
    chk("t1_ds0", bus.port_ds[1:0], 2'b01);
    chk("t1_d0", bus.port_d[15:0], 16'hA5A5);
    chk("t1_p1_req", bus.port_req[1], 0);
    chk("t1_p1_a", bus.port_a[45:23], 0);
    chk("t1_p1_ds", bus.port_ds[3:2], 0);
    wait_idle("t1_idle");
    chk("t1_writes", write_cnt, 1);

    // Overlapping windows: FSM must wait for both acks.
    tick();
    ack_hold = 2'b10;
    send(25'h0E003, 8'h3C, 1'b1);
    repeat (6) tick();
    @(negedge clk_sys);
    chk("t2_wait_both", busy, 1);
    tick();
    ack_hold = 2'b00;
    wait_idle("t2_idle");
    chk("t2_writes", write_cnt, 3);

    // Stalled ack: one byte to the skid, next byte dropped.
    tick();
    ack_hold = 2'b01;
    send(25'h00020, 8'h11, 1'b1);
    send(25'h00022, 8'h22, 1'b1);
    send(25'h00024, 8'h33, 1'b0);
    @(negedge clk_sys);
    chk("t3_overflow", overflow, 1);
    chk("t3_busy", busy, 1);
    chk("t3_stalled_writes", write_cnt, 4);
    repeat (14) tick();
    ack_hold = 2'b00;
    wait_idle("t3_idle");
    chk("t3_writes", write_cnt, 5);
    chk("t3_queue_empty", exp_q.size(), 0);

    // Address past both windows.
    tick();
    busy_seen = 1'b0;
    bus.ioctl_addr = 25'h28200;
    bus.ioctl_dout = 8'h77;
    bus.ioctl_wr   = 1'b1;
    tick();
    bus.ioctl_wr   = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_sys);
      busy_seen = busy_seen | busy;
    end
    chk("t4_busy_never", busy_seen, 0);
    chk("t4_writes", write_cnt, 5);

    // Foreign index: no write, and its download end must not mark the ROM loaded.
    tick();
    bus.ioctl_index = 8'd1;
    send(25'h00010, 8'h99, 1'b0);
    bus.ioctl_download = 1'b0;
    repeat (4) tick();
    @(negedge clk_sys);
    chk("idx1_writes", write_cnt, 5);
    chk("idx1_busy", busy, 0);
    chk("idx1_loaded", rom_loaded, 0);
    tick();
    bus.ioctl_index    = 8'd0;
    bus.ioctl_download = 1'b1;
    tick();

    // Download ends while an ack is outstanding.
    ack_hold = 2'b01;
    send(25'h00030, 8'h44, 1'b1);
    bus.ioctl_download = 1'b0;
    repeat (5) tick();
    @(negedge clk_sys);
    chk("t5_loaded_deferred", rom_loaded, 0);
    chk("t5_busy", busy, 1);
    chk("t5_reset_held", reset_out, 1);
    tick();
    ack_hold = 2'b00;
    n = 0;
    @(negedge clk_sys);
    while (!rom_loaded && n < 100) begin
      n++;
      @(negedge clk_sys);
    end
    chk("t5_loaded", rom_loaded, 1);
    chk("t5_busy_at_load", busy, 0);
    cnt = 0;
    while (reset_out && cnt < 100) begin
      cnt++;
      @(negedge clk_sys);
    end
    chk("t5_reset_hold", cnt, 16);

    // One-cycle user reset pulse.
    tick();
    user_reset = 1'b1;
    @(negedge clk_sys);
    cnt = reset_out ? 1 : 0;
    tick();
    user_reset = 1'b0;
    @(negedge clk_sys);
    while (reset_out && cnt < 100) begin
      cnt++;
      @(negedge clk_sys);
    end
    chk("user_reset_len", cnt, 17);
    chk("user_reset_loaded", rom_loaded, 1);

    // Reset while waiting for an ack.
    tick();
    bus.ioctl_download = 1'b1;
    ack_hold = 2'b01;
    send(25'h00040, 8'h55, 1'b1);
    tick();
    reset_n = 1'b0;
    @(posedge clk_sys);
    @(negedge clk_sys);
    chk("t6_req", bus.port_req, 0);
    chk("t6_a", bus.port_a, 0);
    chk("t6_ds", bus.port_ds, 0);
    chk("t6_d", bus.port_d, 0);
    chk("t6_busy", busy, 0);
    chk("t6_overflow", overflow, 0);
    chk("t6_loaded", rom_loaded, 0);
    chk("t6_reset_out", reset_out, 1);
    chk("t6_we", bus.port_we, 1);
    chk("t6_queue_empty", exp_q.size(), 0);
    tick();
    reset_n  = 1'b1;
    ack_hold = 2'b00;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ioctl_rom_loader.md
Name: ioctl_rom_loader

Overview:
Parametrised ROM download router between data_io's ioctl byte stream and the toggle-handshake write ports of the sdram controller. Routes each downloaded byte to every SDRAM port whose address window contains it, rebased to that window. Waits for each port's ack and buffers one byte of backpressure. Also owns the rom_loaded latch and the stretched core reset that top levels currently hand-code.

Parameters:
NUM_PORTS, 2, number of SDRAM write ports driven (1..4)
AW, 25, ioctl address width
PAW, 23, port word-address width
DL_INDEX, 8'd0, ioctl_index value accepted; other indices are ignored
PORT_BASE, {25'h0E000, 25'h0}, packed NUM_PORTS*AW vector of window base byte addresses; port p uses slice [p*AW +: AW]
PORT_SIZE, {25'h1A100, 25'h28200}, packed NUM_PORTS*AW vector of window lengths in bytes
RESET_HOLD, 16, cycles reset_out stays high after the loaded/user-reset condition clears

Ports:
clk_sys  in  1  system clock
reset_n  in  1  reset; synchronous, active-low
ioctl_download  in  1  download active
ioctl_index  in  8  download index
ioctl_wr  in  1  byte strobe (level; rising edge = new byte)
ioctl_addr  in  AW  byte address
ioctl_dout  in  8  byte data
user_reset  in  1  OSD/button reset request
port_req  out  NUM_PORTS  per-port toggle request
port_ack  in  NUM_PORTS  per-port toggle ack from sdram
port_a  out  NUM_PORTS*PAW  per-port word address (local byte addr >> 1)
port_ds  out  NUM_PORTS*2  per-port byte strobes {a[0], ~a[0]}
port_d  out  NUM_PORTS*16  per-port data, byte duplicated {b,b}
port_we  out  1  high while a download is active or a write is outstanding
busy  out  1  any port outstanding, or skid occupied
overflow  out  1  sticky: byte lost because skid was full
rom_loaded  out  1  sticky: set when a download completes
reset_out  out  1  active-high core reset

Behaviour:
- Reset (reset_n=0 at clk edge): port_req=0, port_a/ds/d=0, busy=0, overflow=0, rom_loaded=0, reset_out=1, FSM=IDLE, skid empty. Requires port_ack=0 from sdram after reset.
- Accept: register ioctl_wr. A byte is accepted on cycle N when wr_q=0, ioctl_wr=1, ioctl_download=1 and ioctl_index==DL_INDEX.
- Hit mask: bit p = (addr >= base_p) && (addr - base_p < size_p). Subtraction is done at AW width. An empty mask drops the byte silently.
- FSM IDLE -> ISSUE -> WAIT_ACK -> IDLE.
- IDLE + accepted byte (or skid occupied): latch addr/data/mask, go to ISSUE.
- ISSUE, one cycle: for each masked port, drive port_a = local[PAW:1], port_ds and port_d, and toggle port_req[p]. Toggle is visible at N+2. Unmasked ports keep their previous outputs.
- WAIT_ACK: leave when port_ack[p]==port_req[p] for every masked p. Go to IDLE, or straight to ISSUE if the skid is occupied (skid pops).
- Skid, one entry: a byte accepted while FSM != IDLE is stored in the skid. A byte accepted while the skid is full is dropped and overflow goes to 1.
- Simultaneous accept and skid pop: the skid pops first and the new byte refills it. No loss.
- port outputs are held stable from ISSUE until the ack is received.
- rom_loaded: set on a falling edge of ioctl_download with index DL_INDEX, once the FSM has drained. A fall while busy defers the set until drain. Cleared only by reset_n.
- reset_out: 1 while user_reset=1 or rom_loaded=0. After both clear, it drops after exactly RESET_HOLD cycles. The counter reloads whenever the condition reasserts.
- port_we = ioctl_download | busy.
- A new download start does not clear rom_loaded. reset_n low mid-transfer aborts without waiting for ack.
- Bytes arriving at index != DL_INDEX are ignored and do not affect rom_loaded.

Decomposition:
- Package ioctl_loader_pkg: fsm state enum (IDLE, ISSUE, WAIT_ACK); helpers base_of(p) and size_of(p) that slice the packed parameters; the AW default.
- One sub-module, ioctl_port_window: per-port hit compare, rebase, and output register. Instantiated NUM_PORTS times in a generate loop.

Test Plan:
- Defaults; byte 8'hA5 at addr 25'h00010 -> port0 only, port_a=8, ds=2'b01, d=16'hA5A5, req0 toggles at N+2; port1 unchanged.
- Byte at 25'h0E003 -> both ports. port0 a=25'h7001>>0 i.e. 0x7001, ds=2'b10. port1 a=0x0001, ds=2'b10. FSM leaves WAIT_ACK only after both acks arrive.
- Hold port_ack 20 cycles and send 2 bytes during the stall -> first byte goes to skid and issues right after the ack; second byte sets overflow=1; no third write occurs.
- Byte at 25'h28200 with defaults -> mask empty, no req toggle, busy stays 0.
- Download falls while WAIT_ACK is pending -> rom_loaded rises only after the ack. reset_out falls exactly 16 cycles later. Pulsing user_reset for 1 cycle -> reset_out high for 17 cycles.
- Write at index 8'd1 -> ignored. reset_n low during WAIT_ACK -> all outputs at reset values on the next edge.
